// File: rtl/midi_tx_encoder_if.sv
// Message handshake bundle for midi_tx_encoder: status plus two data bytes under valid/ready.
interface midi_tx_encoder_if;
  logic       msg_valid;
  logic [7:0] msg_status;
  logic [7:0] msg_data1;
  logic [7:0] msg_data2;
  logic       msg_ready;

  modport master (output msg_valid, msg_status, msg_data1, msg_data2, input msg_ready);
  modport slave  (input msg_valid, msg_status, msg_data1, msg_data2, output msg_ready);
endinterface

// File: rtl/midi_tx_encoder.sv
// MIDI OUT transmitter: takes whole messages, sends them as 8N1 frames at reg_clk/BIT_DIV baud.
// Optional running-status compression is enabled by defining MIDI_RUNNING_STATUS_EN.
module midi_tx_encoder #(
  parameter int BIT_DIV = 1600
) (
  input  logic              reg_clk,
  input  logic              reset_reg_N,
  midi_tx_encoder_if.slave  msg,
  output logic              midi_txd,
  output logic              tx_busy,
  output logic              proto_err,
  output logic [1:0]        fsm_state_o
);

  // Handshake: a message is taken on the rising edge where msg_valid && msg_ready;
  // the source holds msg_* stable until then, and they are don't-care afterwards.
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

  state_t          state_q, state_d;
  logic [11:0]     baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [1:0]      byte_idx_q, byte_idx_d;
  logic [1:0]      len_q, len_d;
  logic [7:0]      shreg_q, shreg_d;
  logic [2:0][7:0] buf_q, buf_d;
  logic            txd_q, txd_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            perr_q, perr_d;

  logic            accept;
  logic            bit_tick;
  logic [1:0]      len_full;
  logic            skip_status;
  logic [7:0]      d1_m, d2_m;
  logic            unused_bits;

  assign accept      = msg.msg_valid && ready_q;
  assign bit_tick    = (baud_cnt_q == 12'(BIT_DIV - 1));
  assign d1_m        = {1'b0, msg.msg_data1[6:0]};
  assign d2_m        = {1'b0, msg.msg_data2[6:0]};
  assign unused_bits = msg.msg_data1[7] ^ msg.msg_data2[7];

  always_comb begin
    len_full = 2'd1;
    case (msg.msg_status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len_full = 2'd3;
      4'hC, 4'hD:                   len_full = 2'd2;
      4'hF: begin
        if (msg.msg_status[3:0] == 4'h2)
          len_full = 2'd3;
        else if (msg.msg_status[3:0] == 4'h1 || msg.msg_status[3:0] == 4'h3)
          len_full = 2'd2;
      end
      default: len_full = 2'd1;
    endcase
  end

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] last_status_q, last_status_d;
  logic       is_channel;

  assign is_channel  = msg.msg_status[7] && (msg.msg_status[7:4] != 4'hF);
  assign skip_status = is_channel && (msg.msg_status == last_status_q);

  // System common/exclusive cancels running status; real-time bytes leave it alone.
  always_comb begin
    last_status_d = last_status_q;
    if (accept && msg.msg_status[7]) begin
      if (is_channel)
        last_status_d = msg.msg_status;
      else if (!msg.msg_status[3])
        last_status_d = 8'h00;
    end
  end

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_N) last_status_q <= 8'h00;
    else              last_status_q <= last_status_d;
  end
`else
  assign skip_status = 1'b0;
`endif

  always_ff @(posedge reg_clk) begin
    if (!reset_reg_N) begin
      state_q    <= IDLE;
      baud_cnt_q <= 12'd0;
      bit_cnt_q  <= 3'd0;
      byte_idx_q <= 2'd0;
      len_q      <= 2'd0;
      shreg_q    <= 8'h00;
      buf_q      <= '0;
      txd_q      <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      len_q      <= len_d;
      shreg_q    <= shreg_d;
      buf_q      <= buf_d;
      txd_q      <= txd_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      perr_q     <= perr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = bit_tick ? 12'd0 : baud_cnt_q + 12'd1;
    bit_cnt_d  = bit_cnt_q;
    byte_idx_d = byte_idx_q;
    len_d      = len_q;
    shreg_d    = shreg_q;
    buf_d      = buf_q;
    perr_d     = 1'b0;
    case (state_q)
      IDLE: begin
        baud_cnt_d = 12'd0;
        if (accept) begin
          if (!msg.msg_status[7]) begin
            perr_d = 1'b1;
          end else begin
            state_d    = START;
            bit_cnt_d  = 3'd0;
            byte_idx_d = 2'd0;
            // buf_d[0] is always the first byte on the line
            if (skip_status) begin
              buf_d   = {8'h00, d2_m, d1_m};
              len_d   = len_full - 2'd1;
              shreg_d = d1_m;
            end else begin
              buf_d   = {d2_m, d1_m, msg.msg_status};
              len_d   = len_full;
              shreg_d = msg.msg_status;
            end
          end
        end
      end
      START: if (bit_tick) state_d = DATA;
      DATA: begin
        if (bit_tick) begin
          shreg_d   = {1'b0, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (byte_idx_q < len_q - 2'd1) begin
            byte_idx_d = byte_idx_q + 2'd1;
            shreg_d    = buf_q[byte_idx_q + 2'd1];
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so the line moves on the same edge as the FSM.
  always_comb begin
    txd_d = 1'b1;
    if (state_d == START)     txd_d = 1'b0;
    else if (state_d == DATA) txd_d = shreg_d[0];
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  assign msg.msg_ready = ready_q;
  assign midi_txd      = txd_q;
  assign tx_busy       = busy_q;
  assign proto_err     = perr_q;
  assign fsm_state_o   = state_q;

endmodule

// File: tb/tb_midi_tx_encoder.sv
// Self-checking bench for midi_tx_encoder: UART frame monitor plus expected-byte scoreboard.
module tb_midi_tx_encoder;
  localparam int BD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       txd, busy, perr;
  logic [1:0] st;

  always #5 clk = ~clk;

  midi_tx_encoder_if mif();

  midi_tx_encoder #(.BIT_DIV(BD)) dut (
    .reg_clk     (clk),
    .reset_reg_N (rst_n),
    .msg         (mif),
    .midi_txd    (txd),
    .tx_busy     (busy),
    .proto_err   (perr),
    .fsm_state_o (st)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         mon_frames = 0;
  logic [7:0] exp_q[$];
`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] mdl_last = 8'h00;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int base_len(input logic [7:0] s);
    if (!s[7]) return 0;
    if (s inside {[8'h80:8'hBF], [8'hE0:8'hEF], 8'hF2}) return 3;
    if (s inside {[8'hC0:8'hDF], 8'hF1, 8'hF3}) return 2;
    return 1;
  endfunction

  // Pushes the bytes the line should carry; returns how many frames that is.
  function automatic int push_model(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    int n;
    int rs;
    n  = base_len(s);
    rs = 0;
`ifdef MIDI_RUNNING_STATUS_EN
    if (s inside {[8'h80:8'hEF]}) begin
      if (s == mdl_last) rs = 1;
      mdl_last = s;
    end else if (s inside {[8'hF0:8'hF7]}) begin
      mdl_last = 8'h00;
    end
`endif
    if (n > 0) begin
      if (rs == 0) exp_q.push_back(s);
      if (n >= 2) exp_q.push_back({1'b0, d1[6:0]});
      if (n == 3) exp_q.push_back({1'b0, d2[6:0]});
    end
    return n - rs;
  endfunction

  task automatic skip_ne(input int n, output logic hit);
    hit = 1'b0;
    repeat (n) begin
      @(negedge clk);
      if (!rst_n) hit = 1'b1;
    end
  endtask

  initial begin : monitor
    logic [7:0] b;
    logic       stop_b, ab, h;
    forever begin
      @(negedge clk);
      if (rst_n && txd == 1'b0) begin
        ab = 1'b0;
        skip_ne(BD / 2, h); ab |= h;
        if (!ab) chk("start_bit", {31'd0, txd}, 32'd0);
        for (int i = 0; i < 8; i++) begin
          skip_ne(BD, h); ab |= h;
          b[i] = txd;
        end
        skip_ne(BD, h); ab |= h;
        stop_b = txd;
        if (!ab) begin
          chk("stop_bit", {31'd0, stop_b}, 32'd1);
          if (exp_q.size() == 0) chk("extra_frame", {24'd0, b}, 32'hFFFF_FFFF);
          else                   chk("frame_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
          mon_frames++;
        end
        skip_ne(BD / 2 - 1, h);
      end
    end
  end

  task automatic send(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2, input int n_req);
    int   n, w, f0, n_mdl;
    logic b1, p1, t1;
    n_mdl = push_model(s, d1, d2);
    chk("model_len", n_mdl, n_req);
    f0 = mon_frames;
    w  = 0;
    while (!mif.msg_ready && w < 2000) begin @(posedge clk); #1; w++; end
    chk("ready_before_timeout", {31'd0, mif.msg_ready}, 32'd1);
    mif.msg_valid  = 1'b1;
    mif.msg_status = s;
    mif.msg_data1  = d1;
    mif.msg_data2  = d2;
    @(posedge clk); #1;
    mif.msg_valid  = 1'b0;
    mif.msg_status = 8'($urandom_range(0, 255));
    mif.msg_data1  = 8'($urandom_range(0, 255));
    mif.msg_data2  = 8'($urandom_range(0, 255));
    n  = 1;
    b1 = busy; p1 = perr; t1 = txd;
    while (!mif.msg_ready && n < 4000) begin @(posedge clk); #1; n++; end
    chk("ready_cycles", n, (n_req == 0) ? 1 : 10 * n_req * BD + 1);
    chk("busy_first", {31'd0, b1}, {31'd0, n_req != 0});
    chk("txd_first", {31'd0, t1}, {31'd0, n_req == 0});
    chk("proto_err_pulse", {31'd0, p1}, {31'd0, !s[7]});
    chk("busy_after", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("proto_err_end", {31'd0, perr}, 32'd0);
    chk("frame_count", mon_frames - f0, n_req);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin : main
    logic [7:0] s;
    mif.msg_valid  = 1'b0;
    mif.msg_status = 8'h00;
    mif.msg_data1  = 8'h00;
    mif.msg_data2  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_ready", {31'd0, mif.msg_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_perr", {31'd0, perr}, 32'd0);
    chk("rst_state", {30'd0, st}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send(8'h90, 8'h3C, 8'h64, 3);
    send(8'hC5, 8'h07, 8'hFF, 2);
    send(8'hF8, 8'h00, 8'h00, 1);
    send(8'h91, 8'hBC, 8'hE4, 3);
    send(8'h3C, 8'h12, 8'h34, 0);

    // Reset during data bit 3 of the first frame
    mif.msg_valid  = 1'b1;
    mif.msg_status = 8'hA0;
    mif.msg_data1  = 8'h11;
    mif.msg_data2  = 8'h22;
    @(posedge clk); #1;
    mif.msg_valid = 1'b0;
    repeat (69) @(posedge clk);
    #1;
    chk("pre_reset_state", {30'd0, st}, 32'd2);
    chk("pre_reset_bit3", {31'd0, txd}, 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_txd", {31'd0, txd}, 32'd1);
    chk("mid_rst_ready", {31'd0, mif.msg_ready}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_state", {30'd0, st}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
`ifdef MIDI_RUNNING_STATUS_EN
    mdl_last = 8'h00;
`endif
    repeat (200) @(posedge clk);
    #1;
    send(8'hB0, 8'h07, 8'h40, 3);

`ifdef MIDI_RUNNING_STATUS_EN
    send(8'h90, 8'h3C, 8'h64, 3);
    send(8'h90, 8'h3E, 8'h64, 2);
    send(8'hF8, 8'h00, 8'h00, 1);
    send(8'h90, 8'h40, 8'h00, 2);
    send(8'hF0, 8'h00, 8'h00, 1);
    send(8'h90, 8'h40, 8'h00, 3);
`else
    send(8'h90, 8'h3C, 8'h64, 3);
    send(8'h90, 8'h3E, 8'h64, 3);
    send(8'hF8, 8'h00, 8'h00, 1);
    send(8'h90, 8'h40, 8'h00, 3);
    send(8'hF0, 8'h00, 8'h00, 1);
    send(8'h90, 8'h40, 8'h00, 3);
`endif

    for (int k = 0; k < 6; k++) begin
      int n_base;
      s = 8'($urandom_range(128, 255));
      n_base = base_len(s);
`ifdef MIDI_RUNNING_STATUS_EN
      if (s inside {[8'h80:8'hEF]} && s == mdl_last) n_base = n_base - 1;
`endif
      send(s, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), n_base);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
